// File: rtl/memtest_sweep_ctrl.sv
// Frequency-step selection, PLL reconfig sequencing with timeout recovery,
// automatic fastest-passing-step sweep, and elapsed-time counters for the overlay.
module memtest_sweep_ctrl #(
   parameter int unsigned NUM_STEPS    = 11,
   parameter int unsigned DEFAULT_POS  = 7,
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned RCFG_TIMEOUT = 1000,
   parameter int unsigned SETTLE       = 1024,
   parameter int unsigned MIN_PASS     = 1,
   parameter int unsigned STEP_W       = $clog2(NUM_STEPS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btn_up,
   input  logic              btn_down,
   input  logic              btn_auto,
   input  logic              start_auto,
   input  logic              tester_rdy,
   input  logic [31:0]       passcount,
   input  logic [31:0]       failcount,
   input  logic              rcfg_busy,
   output logic              rcfg_write_from_rom,
   output logic              rcfg_reconfig,
   output logic              rcfg_reset,
   output logic [STEP_W-1:0] pos,
   output logic              recfg,
   output logic              auto,
   output logic              sweep_done,
   output logic [STEP_W-1:0] best_pos,
   output logic              best_valid,
   output logic [15:0]       mins,
   output logic [15:0]       ticks
);

   localparam int unsigned TMR_W         = $clog2(RCFG_TIMEOUT + 1);
   localparam int unsigned SET_W         = $clog2(SETTLE + 1);
   localparam int unsigned PRESC         = (CLK_HZ / 10 > 0) ? CLK_HZ / 10 : 1;
   localparam int unsigned PRE_W         = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam int unsigned TICKS_PER_MIN = 600;
   localparam int unsigned MIN_W         = 10;
   localparam logic [STEP_W-1:0] LAST_POS = STEP_W'(NUM_STEPS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ARM, ST_RUN} state_e;

   state_e              state_q, state_d;
   logic [TMR_W-1:0]    timer_q, timer_d, timer_dec;
   logic [SET_W-1:0]    settle_q, settle_d;
   logic [STEP_W-1:0]   pos_q, pos_d, best_pos_q, best_pos_d;
   logic                recfg_q, recfg_d, auto_q, auto_d;
   logic                sweep_done_q, sweep_done_d, best_valid_q, best_valid_d;
   logic                wr_q, wr_d, rc_q, rc_d, rr_q, rr_d;
   logic [2:0]          btn_q;
   logic                up_edge, down_edge, auto_edge, idle_ok, eval_ok;
   logic [PRE_W-1:0]    presc_q, presc_d;
   logic [MIN_W-1:0]    min_cnt_q, min_cnt_d;
   logic [15:0]         ticks_q, ticks_d, mins_q, mins_d;

   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      logic        carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[i*4 +: 4] == 4'd9) begin
               r[i*4 +: 4] = 4'd0;
            end else begin
               r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         timer_q      <= '0;
         settle_q     <= '0;
         pos_q        <= STEP_W'(DEFAULT_POS);
         best_pos_q   <= '0;
         recfg_q      <= 1'b1;
         auto_q       <= 1'b0;
         sweep_done_q <= 1'b0;
         best_valid_q <= 1'b0;
         wr_q         <= 1'b0;
         rc_q         <= 1'b0;
         rr_q         <= 1'b0;
         btn_q        <= '0;
         presc_q      <= '0;
         min_cnt_q    <= '0;
         ticks_q      <= '0;
         mins_q       <= '0;
      end else begin
         state_q      <= state_d;
         timer_q      <= timer_d;
         settle_q     <= settle_d;
         pos_q        <= pos_d;
         best_pos_q   <= best_pos_d;
         recfg_q      <= recfg_d;
         auto_q       <= auto_d;
         sweep_done_q <= sweep_done_d;
         best_valid_q <= best_valid_d;
         wr_q         <= wr_d;
         rc_q         <= rc_d;
         rr_q         <= rr_d;
         btn_q        <= {btn_auto, btn_down, btn_up};
         presc_q      <= presc_d;
         min_cnt_q    <= min_cnt_d;
         ticks_q      <= ticks_d;
         mins_q       <= mins_d;
      end
   end

   assign up_edge   = btn_up   & ~btn_q[0];
   assign down_edge = btn_down & ~btn_q[1];
   assign auto_edge = btn_auto & ~btn_q[2];
   assign idle_ok   = (state_q == ST_IDLE) && !recfg_q;
   assign eval_ok   = idle_ok && auto_q && !sweep_done_q && (settle_q == '0) && tester_rdy;
   assign timer_dec = timer_q - 1'b1;

   // Reconfig sequencing first; user/auto requests then override recfg and pos.
   always_comb begin
      state_d      = state_q;
      timer_d      = timer_q;
      settle_d     = (settle_q != '0) ? settle_q - 1'b1 : settle_q;
      pos_d        = pos_q;
      best_pos_d   = best_pos_q;
      recfg_d      = recfg_q;
      auto_d       = auto_q;
      sweep_done_d = sweep_done_q;
      best_valid_d = best_valid_q;
      wr_d         = 1'b0;
      rc_d         = 1'b0;
      rr_d         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (recfg_q) begin
               wr_d    = 1'b1;
               state_d = ST_LOAD;
            end
         end
         ST_LOAD: state_d = ST_ARM;
         ST_ARM: begin
            if (!rcfg_busy) begin
               rc_d    = 1'b1;
               timer_d = TMR_W'(RCFG_TIMEOUT);
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            timer_d = timer_dec;
            if (timer_dec == TMR_W'(1)) begin
               rr_d    = 1'b1;
               recfg_d = 1'b0;
               state_d = ST_IDLE;
            end else if ((timer_q != TMR_W'(RCFG_TIMEOUT)) && !rcfg_busy) begin
               recfg_d  = 1'b0;
               settle_d = SET_W'(SETTLE);
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (start_auto || (idle_ok && auto_edge && !auto_q)) begin
         pos_d        = '0;
         auto_d       = 1'b1;
         sweep_done_d = 1'b0;
         best_valid_d = 1'b0;
         recfg_d      = 1'b1;
      end else if (idle_ok && auto_edge) begin
         auto_d  = 1'b0;
         recfg_d = 1'b1;
      end else if (idle_ok && down_edge && (pos_q != LAST_POS)) begin
         pos_d   = pos_q + STEP_W'(1);
         auto_d  = 1'b0;
         recfg_d = 1'b1;
      end else if (idle_ok && up_edge && (pos_q != '0)) begin
         pos_d   = pos_q - STEP_W'(1);
         auto_d  = 1'b0;
         recfg_d = 1'b1;
      end else if (eval_ok) begin
         if (failcount != 32'd0) begin
            if (pos_q != LAST_POS) begin
               pos_d   = pos_q + STEP_W'(1);
               recfg_d = 1'b1;
            end else begin
               sweep_done_d = 1'b1;
               best_valid_d = 1'b0;
            end
         end else if (passcount >= 32'(MIN_PASS)) begin
            best_pos_d   = pos_q;
            best_valid_d = 1'b1;
            sweep_done_d = 1'b1;
         end
      end
   end

   // 0.1 s prescaler, tick count and BCD minutes; all frozen at zero during reconfig.
   always_comb begin
      presc_d   = presc_q;
      min_cnt_d = min_cnt_q;
      ticks_d   = ticks_q;
      mins_d    = mins_q;
      if (recfg_q) begin
         presc_d   = '0;
         min_cnt_d = '0;
         ticks_d   = '0;
         mins_d    = '0;
      end else if (presc_q == PRE_W'(PRESC - 1)) begin
         presc_d = '0;
         ticks_d = ticks_q + 16'd1;
         if (min_cnt_q == MIN_W'(TICKS_PER_MIN - 1)) begin
            min_cnt_d = '0;
            mins_d    = bcd_inc(mins_q);
         end else begin
            min_cnt_d = min_cnt_q + MIN_W'(1);
         end
      end else begin
         presc_d = presc_q + PRE_W'(1);
      end
   end

   assign rcfg_write_from_rom = wr_q;
   assign rcfg_reconfig       = rc_q;
   assign rcfg_reset          = rr_q;
   assign pos                 = pos_q;
   assign recfg               = recfg_q;
   assign auto                = auto_q;
   assign sweep_done          = sweep_done_q;
   assign best_pos            = best_pos_q;
   assign best_valid          = best_valid_q;
   assign mins                = mins_q;
   assign ticks               = ticks_q;

endmodule

// File: tb/tb_memtest_sweep_ctrl.sv
// Directed/randomised bench for memtest_sweep_ctrl with a PLL busy model and
// a table-driven tester model; expectations come from the sweep/timer rules.
module tb_memtest_sweep_ctrl;

   localparam int unsigned NUM_STEPS = 11;
   localparam int unsigned STEP_W    = 4;
   localparam int unsigned CLK_HZ    = 100;
   localparam int unsigned TIMEOUT   = 1000;
   localparam int unsigned MIN_PASS  = 1;
   localparam int unsigned CPT       = CLK_HZ / 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic              btn_up = 1'b0, btn_down = 1'b0, btn_auto = 1'b0, start_auto = 1'b0;
   logic              tester_rdy;
   logic [31:0]       passcount, failcount;
   logic              rcfg_busy = 1'b0;
   logic              rcfg_write_from_rom, rcfg_reconfig, rcfg_reset;
   logic [STEP_W-1:0] pos, best_pos;
   logic              recfg, auto, sweep_done, best_valid;
   logic [15:0]       mins, ticks;

   int unsigned fail_tbl [NUM_STEPS];
   int unsigned pass_tbl [NUM_STEPS];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int n_wr = 0, n_rc = 0, n_rr = 0;
   int last_wr = 0, last_rc = 0, last_rr = 0;
   int wide = 0;
   logic prev_wr = 1'b0, prev_rc = 1'b0, prev_rr = 1'b0;
   logic hold_busy = 1'b0;
   int busy_left = 0;

   memtest_sweep_ctrl #(
      .NUM_STEPS(NUM_STEPS), .DEFAULT_POS(7), .CLK_HZ(CLK_HZ),
      .RCFG_TIMEOUT(TIMEOUT), .SETTLE(1024), .MIN_PASS(MIN_PASS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_down(btn_down),
      .btn_auto(btn_auto), .start_auto(start_auto), .tester_rdy(tester_rdy),
      .passcount(passcount), .failcount(failcount), .rcfg_busy(rcfg_busy),
      .rcfg_write_from_rom(rcfg_write_from_rom), .rcfg_reconfig(rcfg_reconfig),
      .rcfg_reset(rcfg_reset), .pos(pos), .recfg(recfg), .auto(auto),
      .sweep_done(sweep_done), .best_pos(best_pos), .best_valid(best_valid),
      .mins(mins), .ticks(ticks)
   );

   always #5 clk = ~clk;

   // Tester model: held in reset by recfg, reports counters for the current step.
   assign tester_rdy = ~recfg;
   assign failcount  = fail_tbl[pos];
   assign passcount  = pass_tbl[pos];

   // Pulse monitor and PLL busy model, sampled shortly after each rising edge.
   always @(posedge clk) begin
      #2;
      cyc++;
      if (rcfg_write_from_rom) begin n_wr++; last_wr = cyc; end
      if (rcfg_reconfig)       begin n_rc++; last_rc = cyc; end
      if (rcfg_reset)          begin n_rr++; last_rr = cyc; end
      if ((rcfg_write_from_rom && prev_wr) || (rcfg_reconfig && prev_rc) || (rcfg_reset && prev_rr))
         wide++;
      prev_wr = rcfg_write_from_rom;
      prev_rc = rcfg_reconfig;
      prev_rr = rcfg_reset;
      if (rcfg_reconfig) begin
         rcfg_busy = 1'b1;
         busy_left = int'($urandom_range(2, 20));
      end else if (rcfg_busy && !hold_busy) begin
         if (busy_left > 0) busy_left--;
         else rcfg_busy = 1'b0;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input int which);
      @(negedge clk);
      case (which)
         0: btn_up = 1'b1;
         1: btn_down = 1'b1;
         default: btn_auto = 1'b1;
      endcase
      @(negedge clk);
      btn_up = 1'b0; btn_down = 1'b0; btn_auto = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int n = 0; n < budget && recfg !== 1'b0; n++) @(negedge clk);
      check({tag, "_idle"}, 32'(recfg), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   task automatic wait_done(input string tag, input int budget);
      for (int n = 0; n < budget && sweep_done !== 1'b1; n++) @(negedge clk);
      check({tag, "_done"}, 32'(sweep_done), 32'd1);
   endtask

   // Reference sweep: fastest step whose tester run is clean, else -1.
   function automatic int model_sweep();
      for (int i = 0; i < int'(NUM_STEPS); i++)
         if (fail_tbl[i] == 0 && pass_tbl[i] >= MIN_PASS) return i;
      return -1;
   endfunction

   function automatic logic [15:0] to_bcd(input int unsigned v);
      return 16'(((v / 1000) % 10) * 4096 + ((v / 100) % 10) * 256 + ((v / 10) % 10) * 16 + v % 10);
   endfunction

   initial begin
      int k, p, exp_best, wr0, n;
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
         fail_tbl[i] = 0;
         pass_tbl[i] = 1;
      end

      // Reset state
      #2 rst_n = 1'b0;
      #20;
      check("rst_pos", 32'(pos), 32'd7);
      check("rst_recfg", 32'(recfg), 32'd1);
      check("rst_flags", 32'({auto, sweep_done, best_valid}), 32'd0);
      check("rst_best_pos", 32'(best_pos), 32'd0);
      check("rst_pulses", 32'({rcfg_write_from_rom, rcfg_reconfig, rcfg_reset}), 32'd0);
      check("rst_timer", {mins, ticks}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Startup reconfig
      wait_idle("startup", 200);
      check("startup_wr", 32'(n_wr), 32'd1);
      check("startup_rc", 32'(n_rc), 32'd1);
      check("startup_gap", 32'(last_rc - last_wr), 32'd2);
      check("startup_pos", 32'(pos), 32'd7);

      // Eight up presses from step 7
      wr0 = n_wr;
      press(0);
      check("up1_recfg", 32'(recfg), 32'd1);
      check("up1_pos", 32'(pos), 32'd6);
      @(negedge clk);
      check("up1_wr_pulse", 32'(rcfg_write_from_rom), 32'd1);
      wait_idle("up1", 200);
      check("up1_gap", 32'(last_rc - last_wr), 32'd2);
      for (int i = 1; i < 8; i++) begin
         press(0);
         if (i == 7) check("up8_norecfg", 32'(recfg), 32'd0);
         wait_idle("upn", 200);
         check("upn_pos", 32'(pos), 32'((6 - i) > 0 ? (6 - i) : 0));
      end
      check("up_reconfigs", 32'(n_wr - wr0), 32'd7);

      // Random number of down presses
      k = int'($urandom_range(1, 3));
      for (int i = 0; i < k; i++) begin
         press(1);
         wait_idle("down", 200);
      end
      check("down_pos", 32'(pos), 32'(k));

      // Timeout recovery with busy stuck high
      hold_busy = 1'b1;
      n = n_rr;
      press(1);
      for (int i = 0; i < 1200 && n_rr == n; i++) @(negedge clk);
      check("to_count", 32'(n_rr - n), 32'd1);
      check("to_gap", 32'(last_rr - last_rc), 32'(TIMEOUT - 1));
      check("to_recfg", 32'(recfg), 32'd0);
      check("to_pos", 32'(pos), 32'(k + 1));
      hold_busy = 1'b0;
      repeat (30) @(negedge clk);
      press(0);
      check("after_to_recfg", 32'(recfg), 32'd1);
      wait_idle("after_to", 200);
      check("after_to_pos", 32'(pos), 32'(k));

      // Auto sweep with a random first clean step
      p = int'($urandom_range(0, NUM_STEPS - 1));
      for (int i = 0; i < int'(NUM_STEPS); i++) begin
         fail_tbl[i] = (i < p) ? $urandom_range(1, 1000) : ((i == p) ? 0 : $urandom_range(0, 50));
         pass_tbl[i] = (i == p) ? $urandom_range(1, 9) : $urandom_range(0, 9);
      end
      exp_best = model_sweep();
      wr0 = n_wr;
      @(negedge clk);
      start_auto = 1'b1;
      @(negedge clk);
      start_auto = 1'b0;
      check("sa_pos", 32'(pos), 32'd0);
      check("sa_auto", 32'({auto, recfg}), 32'd3);
      wait_done("sweep1", 16000);
      check("sweep1_best_pos", 32'(best_pos), 32'(exp_best));
      check("sweep1_best_valid", 32'(best_valid), 32'd1);
      check("sweep1_pos", 32'(pos), 32'(exp_best));
      check("sweep1_auto", 32'(auto), 32'd1);
      check("sweep1_reconfigs", 32'(n_wr - wr0), 32'(exp_best + 1));

      // Auto off, then an all-failing sweep via the auto button
      press(2);
      check("aoff_auto", 32'(auto), 32'd0);
      check("aoff_pos", 32'(pos), 32'(exp_best));
      check("aoff_recfg", 32'(recfg), 32'd1);
      wait_idle("aoff", 200);
      for (int i = 0; i < int'(NUM_STEPS); i++) fail_tbl[i] = $urandom_range(1, 100);
      wr0 = n_wr;
      press(2);
      check("aon_state", 32'({auto, sweep_done, best_valid}), 32'b100);
      check("aon_pos", 32'(pos), 32'd0);
      wait_done("sweep2", 16000);
      check("sweep2_model", 32'(model_sweep()), 32'hffff_ffff);
      check("sweep2_pos", 32'(pos), 32'(NUM_STEPS - 1));
      check("sweep2_best_valid", 32'(best_valid), 32'd0);
      check("sweep2_reconfigs", 32'(n_wr - wr0), 32'(NUM_STEPS));
      press(1);
      check("down_limit_recfg", 32'(recfg), 32'd0);
      repeat (3) @(negedge clk);
      check("down_limit_pos", 32'(pos), 32'(NUM_STEPS - 1));

      // Elapsed-time counters
      press(0);
      for (int i = 0; i < 200 && recfg !== 1'b0; i++) @(negedge clk);
      n = 6000 + int'($urandom_range(0, 400));
      repeat (n) @(negedge clk);
      check("timer_ticks", 32'(ticks), 32'((n / CPT) % 65536));
      check("timer_mins", 32'(mins), 32'(to_bcd(32'(n / (CPT * 600)))));
      press(1);
      @(negedge clk);
      check("timer_clear", {mins, ticks}, 32'd0);
      wait_idle("timer", 200);

      // Asynchronous reset in the middle of a reconfig
      press(0);
      for (int i = 0; i < 10 && rcfg_write_from_rom !== 1'b1; i++) @(negedge clk);
      check("mid_wr_seen", 32'(rcfg_write_from_rom), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("mid_pulses", 32'({rcfg_write_from_rom, rcfg_reconfig, rcfg_reset}), 32'd0);
      check("mid_pos", 32'(pos), 32'd7);
      check("mid_flags", 32'({recfg, auto, sweep_done, best_valid}), 32'b1000);
      check("mid_best_pos", 32'(best_pos), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_idle("mid", 200);
      check("mid_after_pos", 32'(pos), 32'd7);

      check("pulse_width", 32'(wide), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
